wdma: RTL and testbench

AXI4 write-DMA master: drains a FIFO-style write stream from the compute datapath and writes it to global memory at `mem` for `transfer_byte` bytes. It is the write-side counterpart of the read DMA, using the same ap_ctrl start/idle/ready/done control. Addresses are split into INCR bursts of at most 4 beats that never cross a 4 KB boundary. Up to 4 bursts may be outstanding, and the block reports done only after every B response has been received.

---
 rtl/wdma.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_wdma.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdma.sv
// wdma: AXI4 write-DMA master. Drains the din/wr_en stream into global memory
// at `mem` as INCR bursts of up to 4 beats that never cross a 4 KB page, with
// up to 4 bursts in flight. ap_ctrl start/idle/ready/done handshake.
module wdma #(
   parameter int C_M_AXI_GMEM_ID_WIDTH     = 1,
   parameter int C_M_AXI_GMEM_ADDR_WIDTH   = 32,
   parameter int C_M_AXI_GMEM_DATA_WIDTH   = 64,
   parameter int C_M_AXI_GMEM_AWUSER_WIDTH = 1,
   parameter int C_M_AXI_GMEM_WUSER_WIDTH  = 1,
   parameter int C_M_AXI_GMEM_BUSER_WIDTH  = 1
) (
   input  logic                                   ap_clk,
   input  logic                                   ap_rst,
   input  logic                                   ap_start,
   output logic                                   ap_idle,
   output logic                                   ap_ready,
   output logic                                   ap_done,
   input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]     transfer_byte,
   input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]     mem,
   output logic                                   bresp_err,
   // AW channel
   output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]       m_axi_gmem_AWID,
   output logic                                   m_axi_gmem_AWVALID,
   input  logic                                   m_axi_gmem_AWREADY,
   output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]     m_axi_gmem_AWADDR,
   output logic [7:0]                             m_axi_gmem_AWLEN,
   output logic [2:0]                             m_axi_gmem_AWSIZE,
   output logic [1:0]                             m_axi_gmem_AWBURST,
   output logic [1:0]                             m_axi_gmem_AWLOCK,
   output logic [3:0]                             m_axi_gmem_AWCACHE,
   output logic [2:0]                             m_axi_gmem_AWPROT,
   output logic [3:0]                             m_axi_gmem_AWQOS,
   output logic [3:0]                             m_axi_gmem_AWREGION,
   output logic [C_M_AXI_GMEM_AWUSER_WIDTH-1:0]   m_axi_gmem_AWUSER,
   // W channel
   output logic                                   m_axi_gmem_WVALID,
   input  logic                                   m_axi_gmem_WREADY,
   output logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]     m_axi_gmem_WDATA,
   output logic [C_M_AXI_GMEM_DATA_WIDTH/8-1:0]   m_axi_gmem_WSTRB,
   output logic                                   m_axi_gmem_WLAST,
   output logic [C_M_AXI_GMEM_WUSER_WIDTH-1:0]    m_axi_gmem_WUSER,
   // B channel
   input  logic [C_M_AXI_GMEM_ID_WIDTH-1:0]       m_axi_gmem_BID,
   input  logic                                   m_axi_gmem_BVALID,
   output logic                                   m_axi_gmem_BREADY,
   input  logic [1:0]                             m_axi_gmem_BRESP,
   input  logic [C_M_AXI_GMEM_BUSER_WIDTH-1:0]    m_axi_gmem_BUSER,
   // write stream
   output logic                                   full_n,
   input  logic                                   wr_en,
   input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]     din
);
   localparam int AW    = C_M_AXI_GMEM_ADDR_WIDTH;
   localparam int DW    = C_M_AXI_GMEM_DATA_WIDTH;
   localparam int SHIFT = $clog2(DW / 8);
   localparam int CW    = AW - SHIFT;
   localparam int PB    = 4096 >> SHIFT;   // beats per 4 KB page

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_DONE} main_t;
   typedef enum logic [1:0] {A_IDLE, A_PRE, A_RUN} aw_t;
   typedef enum logic       {W_IDLE, W_RUN} w_t;

   main_t            st, st_nx;
   aw_t              aw_st, aw_st_nx;
   w_t               w_st, w_st_nx;

   logic             start_d, go;
   logic [AW-1:0]    xfer_r, base_r;
   logic [CW-1:0]    num_beats, aw_beats, aw_bursts, b_bursts;
   logic [2:0]       len_r;
   logic             aw_hs, b_hs, w_hs, w_last_hs, is_done, can_issue;

   // burst sizing
   logic [AW-1:0]    addr_c;
   logic [CW-1:0]    remaining;
   logic [2:0]       normal, len_c;
   logic [13:0]      pg_off;

   // AW->W length FIFO
   logic [2:0]       lq [4];
   logic [1:0]       lq_wp, lq_rp;
   logic [2:0]       lq_cnt;
   logic [2:0]       wlen;
   logic [1:0]       w_cnt;

   // data buffer
   logic [DW-1:0]    db [2];
   logic             db_wp, db_rp, wr_acc;
   logic [1:0]       db_cnt;

   logic             unused_ok;
   assign unused_ok = ^{m_axi_gmem_BID, m_axi_gmem_BUSER, xfer_r};

   assign go        = ap_start & ~start_d & (st == S_IDLE);
   assign aw_hs     = m_axi_gmem_AWVALID & m_axi_gmem_AWREADY;
   assign b_hs      = m_axi_gmem_BVALID & m_axi_gmem_BREADY;
   assign w_hs      = m_axi_gmem_WVALID & m_axi_gmem_WREADY;
   assign w_last_hs = w_hs & m_axi_gmem_WLAST;
   assign can_issue = (aw_bursts - b_bursts) < CW'(4);
   assign is_done   = (aw_beats >= num_beats) & (b_bursts == aw_bursts) & (aw_st == A_IDLE);

   // constant AXI fields
   assign m_axi_gmem_AWID     = '0;
   assign m_axi_gmem_AWSIZE   = 3'(SHIFT);
   assign m_axi_gmem_AWBURST  = 2'b01;
   assign m_axi_gmem_AWLOCK   = '0;
   assign m_axi_gmem_AWCACHE  = '0;
   assign m_axi_gmem_AWPROT   = '0;
   assign m_axi_gmem_AWQOS    = '0;
   assign m_axi_gmem_AWREGION = '0;
   assign m_axi_gmem_AWUSER   = '0;
   assign m_axi_gmem_WUSER    = '0;
   assign m_axi_gmem_WSTRB    = '1;

   // start-edge detect and sampling of the transfer arguments
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         start_d   <= 1'b0;
         xfer_r    <= '0;
         base_r    <= '0;
         num_beats <= '0;
      end else begin
         start_d <= ap_start;
         if (go) begin
            xfer_r <= transfer_byte;
            base_r <= mem;
         end
         if (st == S_PRE) num_beats <= CW'(xfer_r >> SHIFT);
      end
   end

   // main FSM state register
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) st <= S_IDLE;
      else        st <= st_nx;

   // main FSM next state
   always_comb begin
      st_nx = st;
      case (st)
         S_IDLE: if (go) st_nx = S_PRE;
         S_PRE:  st_nx = S_RUN;
         S_RUN:  if (is_done) st_nx = S_DONE;
         S_DONE: st_nx = S_IDLE;
         default: st_nx = S_IDLE;
      endcase
   end

   // main FSM outputs
   always_comb begin
      ap_idle           = (st == S_IDLE);
      ap_ready          = (st == S_PRE);
      ap_done           = (st == S_DONE);
      m_axi_gmem_BREADY = (st != S_IDLE);
   end

   // beat/burst bookkeeping, held at zero between transfers
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         aw_beats  <= '0;
         aw_bursts <= '0;
         b_bursts  <= '0;
      end else if (st == S_IDLE) begin
         aw_beats  <= '0;
         aw_bursts <= '0;
         b_bursts  <= '0;
      end else begin
         if (aw_hs) begin
            aw_beats  <= aw_beats + CW'(len_r);
            aw_bursts <= aw_bursts + CW'(1);
         end
         if (b_hs) b_bursts <= b_bursts + CW'(1);
      end
   end

   // sticky error flag for any non-OKAY write response
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst)                             bresp_err <= 1'b0;
      else if (go)                            bresp_err <= 1'b0;
      else if (b_hs && m_axi_gmem_BRESP != 0) bresp_err <= 1'b1;

   // next burst address and length, clipped at the 4 KB page end
   always_comb begin
      addr_c    = base_r + (AW'(aw_beats) << SHIFT);
      remaining = num_beats - aw_beats;
      normal    = (remaining > CW'(4)) ? 3'd4 : remaining[2:0];
      pg_off    = 14'(addr_c[11:SHIFT]);
      len_c     = (pg_off + 14'(normal) > 14'(PB)) ? 3'(14'(PB) - pg_off) : normal;
   end

   // AW FSM state register
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) aw_st <= A_IDLE;
      else        aw_st <= aw_st_nx;

   // AW FSM next state
   always_comb begin
      aw_st_nx = aw_st;
      case (aw_st)
         A_IDLE: if (st == S_RUN && aw_beats < num_beats && can_issue) aw_st_nx = A_PRE;
         A_PRE:  aw_st_nx = A_RUN;
         A_RUN:  if (m_axi_gmem_AWREADY) aw_st_nx = A_IDLE;
         default: aw_st_nx = A_IDLE;
      endcase
   end

   // AW FSM outputs
   always_comb m_axi_gmem_AWVALID = (aw_st == A_RUN);

   // AW address/length registers, loaded only in PRE so they hold until AWREADY
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         m_axi_gmem_AWADDR <= '0;
         m_axi_gmem_AWLEN  <= '0;
         len_r             <= '0;
      end else if (aw_st == A_PRE) begin
         m_axi_gmem_AWADDR <= addr_c;
         m_axi_gmem_AWLEN  <= 8'(len_c) - 8'd1;
         len_r             <= len_c;
      end
   end

   // AW->W length FIFO pointers; occupancy is bounded by the 4-burst limit
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         lq_wp  <= '0;
         lq_rp  <= '0;
         lq_cnt <= '0;
      end else begin
         if (aw_hs)     lq_wp <= lq_wp + 2'd1;
         if (w_last_hs) lq_rp <= lq_rp + 2'd1;
         lq_cnt <= lq_cnt + {2'b0, aw_hs} - {2'b0, w_last_hs};
      end
   end

   // AW->W length FIFO storage
   always_ff @(posedge ap_clk)
      if (aw_hs) lq[lq_wp] <= len_r;

   assign wlen = lq[lq_rp];

   // W FSM state register
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) w_st <= W_IDLE;
      else        w_st <= w_st_nx;

   // W FSM next state: leave RUN only when the last queued burst completes
   always_comb begin
      w_st_nx = w_st;
      case (w_st)
         W_IDLE: if (lq_cnt != 3'd0) w_st_nx = W_RUN;
         W_RUN:  if (w_last_hs && lq_cnt == 3'd1 && !aw_hs) w_st_nx = W_IDLE;
         default: w_st_nx = W_IDLE;
      endcase
   end

   // W FSM outputs, all from registers
   always_comb begin
      m_axi_gmem_WVALID = (w_st == W_RUN) && (db_cnt != 2'd0);
      m_axi_gmem_WLAST  = (w_st == W_RUN) && ({1'b0, w_cnt} == wlen - 3'd1);
      m_axi_gmem_WDATA  = db[db_rp];
   end

   // beat counter within the current W burst
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst)         w_cnt <= '0;
      else if (w_last_hs) w_cnt <= '0;
      else if (w_hs)      w_cnt <= w_cnt + 2'd1;

   assign full_n = (db_cnt != 2'd2);
   assign wr_acc = wr_en & full_n;

   // data buffer pointers and occupancy
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         db_wp  <= 1'b0;
         db_rp  <= 1'b0;
         db_cnt <= 2'd0;
      end else begin
         if (wr_acc) db_wp <= ~db_wp;
         if (w_hs)   db_rp <= ~db_rp;
         db_cnt <= db_cnt + {1'b0, wr_acc} - {1'b0, w_hs};
      end
   end

   // data buffer storage
   always_ff @(posedge ap_clk)
      if (wr_acc) db[db_wp] <= din;

endmodule

// File: tb/tb_wdma.sv
// tb_wdma: directed bench for wdma with a behavioural AXI slave and stream source.
module tb_wdma;
   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_idle, ap_ready, ap_done, bresp_err;
   logic [31:0] transfer_byte = '0, mem = '0;
   logic [0:0]  awid, awuser, wuser, bid, buser;
   logic        awvalid, wvalid, wlast, bready, full_n;
   logic        aw_rdy = 1'b1, w_rdy = 1'b1, bvalid = 1'b0, wr_en = 1'b0;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst, awlock, bresp = 2'b00;
   logic [3:0]  awcache, awqos, awregion;
   logic [63:0] wdata, din = '0;
   logic [7:0]  wstrb;

   assign bid   = '0;
   assign buser = '0;

   always #5 ap_clk = ~ap_clk;

   wdma dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
      .transfer_byte(transfer_byte), .mem(mem), .bresp_err(bresp_err),
      .m_axi_gmem_AWID(awid), .m_axi_gmem_AWVALID(awvalid), .m_axi_gmem_AWREADY(aw_rdy),
      .m_axi_gmem_AWADDR(awaddr), .m_axi_gmem_AWLEN(awlen), .m_axi_gmem_AWSIZE(awsize),
      .m_axi_gmem_AWBURST(awburst), .m_axi_gmem_AWLOCK(awlock), .m_axi_gmem_AWCACHE(awcache),
      .m_axi_gmem_AWPROT(awprot), .m_axi_gmem_AWQOS(awqos), .m_axi_gmem_AWREGION(awregion),
      .m_axi_gmem_AWUSER(awuser),
      .m_axi_gmem_WVALID(wvalid), .m_axi_gmem_WREADY(w_rdy), .m_axi_gmem_WDATA(wdata),
      .m_axi_gmem_WSTRB(wstrb), .m_axi_gmem_WLAST(wlast), .m_axi_gmem_WUSER(wuser),
      .m_axi_gmem_BID(bid), .m_axi_gmem_BVALID(bvalid), .m_axi_gmem_BREADY(bready),
      .m_axi_gmem_BRESP(bresp), .m_axi_gmem_BUSER(buser),
      .full_n(full_n), .wr_en(wr_en), .din(din)
   );

   // stimulus controls, written only by the main sequence
   int          clr_seq = 0, prod_total = 0;
   logic [63:0] base_val = '0;
   bit          w_rdy_cfg = 1'b1, wtoggle = 1'b0, b_en = 1'b1, err_arm = 1'b0;

   // slave/source state, written only by the negedge process
   logic [31:0] aw_addr_l[$];
   logic [7:0]  aw_len_l[$];
   logic [63:0] wd_l[$];
   logic [63:0] wlast_mask = '0, st_wd = '0;
   logic [31:0] st_aa = '0;
   logic [7:0]  st_al = '0;
   int          last_clr = 0, pend = 0, done_cnt = 0, prod_sent = 0, viol = 0;
   bit          seen_full = 0, idle_ok = 0, prev_done = 0, err_used = 0;
   bit          st_w = 0, st_wl = 0, st_a = 0;

   // inputs are driven at the falling edge; the handshakes that the next
   // rising edge will see are then decided from the now-stable values
   always @(negedge ap_clk) begin
      if (clr_seq != last_clr) begin
         last_clr = clr_seq;
         aw_addr_l.delete(); aw_len_l.delete(); wd_l.delete();
         wlast_mask = '0; pend = 0; done_cnt = 0; prod_sent = 0; viol = 0;
         seen_full = 0; idle_ok = 0; prev_done = 0; err_used = 0;
         st_w = 0; st_a = 0; wr_en = 1'b0; bvalid = 1'b0;
      end else begin
         w_rdy = wtoggle ? ~w_rdy : w_rdy_cfg;
         if (!ap_rst && full_n && prod_sent < prod_total) begin
            wr_en = 1'b1;
            din   = base_val + 64'(prod_sent);
         end else wr_en = 1'b0;
         bvalid = (pend > 0) && b_en;
         bresp  = (err_arm && !err_used) ? 2'b10 : 2'b00;
         if (st_w && (!wvalid || wdata != st_wd || wlast != st_wl)) viol++;
         if (st_a && (!awvalid || awaddr != st_aa || awlen != st_al)) viol++;
         if (prev_done) idle_ok = ap_idle;
         prev_done = ap_done;
         if (ap_done) done_cnt++;
         if (!full_n) seen_full = 1;
         if (wr_en) prod_sent++;
         if (awvalid && aw_rdy) begin
            aw_addr_l.push_back(awaddr);
            aw_len_l.push_back(awlen);
         end
         if (wvalid && w_rdy) begin
            wd_l.push_back(wdata);
            if (wlast) begin
               wlast_mask = wlast_mask | (64'd1 << (wd_l.size() - 1));
               pend++;
            end
         end
         if (bvalid && bready) begin
            pend--;
            if (bresp != 2'b00) err_used = 1;
         end
         st_w = wvalid && !w_rdy; st_wd = wdata; st_wl = wlast;
         st_a = awvalid && !aw_rdy; st_aa = awaddr; st_al = awlen;
         if (ap_rst) begin pend = 0; st_w = 0; st_a = 0; end
      end
   end

   int vecs = 0, miss = 0;
   logic t_ready, t_berr, t_aw3, t_aw4, t_done3;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] aw_a(input int i);
      return (i < aw_addr_l.size()) ? aw_addr_l[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [7:0] aw_l(input int i);
      return (i < aw_len_l.size()) ? aw_len_l[i] : 8'hFF;
   endfunction

   // start a transfer and capture control timing for the first few cycles
   task automatic start_xfer(input logic [31:0] a, input logic [31:0] n, input int words,
                             input logic [63:0] bv, input bit hold);
      prod_total = 0;
      clr_seq++;
      @(negedge ap_clk);
      mem = a; transfer_byte = n; base_val = bv; prod_total = words;
      ap_start = 1'b1;
      @(posedge ap_clk); #1 t_ready = ap_ready; t_berr = bresp_err;
      @(posedge ap_clk); #1;
      @(posedge ap_clk); #1 t_aw3 = awvalid; t_done3 = ap_done;
      @(posedge ap_clk); #1 t_aw4 = awvalid;
      if (!hold) ap_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge ap_clk);
         if (done_cnt > 0 && ap_idle) break;
      end
      chk("done_wait", {63'd0, done_cnt > 0 && ap_idle}, 64'd1);
      repeat (3) @(negedge ap_clk);
   endtask

   task automatic chk_data(input string tag, input int n, input logic [63:0] bv);
      int bad = 0;
      chk({tag, "_cnt"}, 64'(wd_l.size()), 64'(n));
      for (int i = 0; i < wd_l.size(); i++)
         if (wd_l[i] !== bv + 64'(i)) bad++;
      chk({tag, "_order"}, 64'(bad), 64'd0);
   endtask

   initial begin
      // reset values
      #12;
      chk("rst_idle", {63'd0, ap_idle}, 64'd1);
      chk("rst_ready", {63'd0, ap_ready}, 64'd0);
      chk("rst_done", {63'd0, ap_done}, 64'd0);
      chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
      chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
      chk("rst_wlast", {63'd0, wlast}, 64'd0);
      chk("rst_bready", {63'd0, bready}, 64'd0);
      chk("rst_awaddr", 64'(awaddr), 64'd0);
      chk("rst_awlen", 64'(awlen), 64'd0);
      chk("rst_berr", {63'd0, bresp_err}, 64'd0);
      chk("rst_full_n", {63'd0, full_n}, 64'd1);
      @(negedge ap_clk) ap_rst = 1'b0;

      // 64 bytes at 0x1000: two 4-beat bursts
      start_xfer(32'h1000, 32'd64, 8, 64'h100, 1'b0);
      chk("t1_ready_c1", {63'd0, t_ready}, 64'd1);
      chk("t1_awv_c3", {63'd0, t_aw3}, 64'd0);
      chk("t1_awv_c4", {63'd0, t_aw4}, 64'd1);
      chk("t1_awconst", {43'd0, awsize, awburst, wstrb, awlock, awcache, awid},
          {43'd0, 3'd3, 2'b01, 8'hFF, 2'b00, 4'h0, 1'b0});
      wait_done(200);
      chk("t1_aw_n", 64'(aw_addr_l.size()), 64'd2);
      chk("t1_aw0", {aw_a(0), 24'd0, aw_l(0)}, {32'h1000, 24'd0, 8'd3});
      chk("t1_aw1", {aw_a(1), 24'd0, aw_l(1)}, {32'h1020, 24'd0, 8'd3});
      chk_data("t1_data", 8, 64'h100);
      chk("t1_wlast", wlast_mask, 64'h88);
      chk("t1_done_n", 64'(done_cnt), 64'd1);
      chk("t1_idle_after", {63'd0, idle_ok}, 64'd1);

      // 48 bytes at 0x0FF0: first burst clipped at the 4 KB boundary
      start_xfer(32'h0FF0, 32'd48, 6, 64'h200, 1'b0);
      wait_done(200);
      chk("t2_aw_n", 64'(aw_addr_l.size()), 64'd2);
      chk("t2_aw0", {aw_a(0), 24'd0, aw_l(0)}, {32'h0FF0, 24'd0, 8'd1});
      chk("t2_aw1", {aw_a(1), 24'd0, aw_l(1)}, {32'h1000, 24'd0, 8'd3});
      chk_data("t2_data", 6, 64'h200);
      chk("t2_wlast", wlast_mask, 64'h22);

      // 20 bytes: 2 beats, remainder dropped; ap_start held high throughout
      start_xfer(32'h2000, 32'd20, 2, 64'h300, 1'b1);
      wait_done(200);
      repeat (10) @(negedge ap_clk);
      chk("t3_aw_n", 64'(aw_addr_l.size()), 64'd1);
      chk("t3_aw0", {aw_a(0), 24'd0, aw_l(0)}, {32'h2000, 24'd0, 8'd1});
      chk_data("t3_data", 2, 64'h300);
      chk("t3_no_restart", {62'd0, ap_idle, done_cnt == 1}, 64'd3);
      ap_start = 1'b0;
      @(negedge ap_clk);

      // 40 beats with B withheld: at most 4 bursts in flight
      b_en = 1'b0;
      start_xfer(32'h3000, 32'd320, 40, 64'h400, 1'b0);
      repeat (60) @(negedge ap_clk);
      chk("t4_aw_stall_n", 64'(aw_addr_l.size()), 64'd4);
      chk("t4_awv_low", {63'd0, awvalid}, 64'd0);
      chk("t4_wlast_n", 64'(pend), 64'd4);
      b_en = 1'b1;
      wait_done(800);
      begin
         int bad = 0;
         for (int i = 0; i < 10; i++)
            if (aw_a(i) !== 32'h3000 + 32'(i * 32) || aw_l(i) !== 8'd3) bad++;
         chk("t4_aw_n", 64'(aw_addr_l.size()), 64'd10);
         chk("t4_aw_list", 64'(bad), 64'd0);
      end
      chk_data("t4_data", 40, 64'h400);
      chk("t4_done_n", 64'(done_cnt), 64'd1);

      // WREADY toggling: no loss, stable while stalled, buffer fills
      wtoggle = 1'b1;
      start_xfer(32'h4000, 32'd64, 8, 64'h500, 1'b0);
      wait_done(300);
      wtoggle = 1'b0;
      chk_data("t5_data", 8, 64'h500);
      chk("t5_stable", 64'(viol), 64'd0);
      chk("t5_full_seen", {63'd0, seen_full}, 64'd1);
      chk("t5_wlast", wlast_mask, 64'h88);

      // error response on the first burst sets the sticky flag
      err_arm = 1'b1;
      start_xfer(32'h5000, 32'd64, 8, 64'h600, 1'b0);
      wait_done(200);
      err_arm = 1'b0;
      chk("t6_berr_set", {63'd0, bresp_err}, 64'd1);
      chk("t6_err_used", {63'd0, err_used}, 64'd1);
      chk_data("t6_data", 8, 64'h600);

      // zero-beat transfer: clears the flag, done at cycle 3, no traffic
      start_xfer(32'h7000, 32'd0, 0, 64'h0, 1'b0);
      chk("t7_berr_clr", {63'd0, t_berr}, 64'd0);
      chk("t7_done_c3", {63'd0, t_done3}, 64'd1);
      wait_done(50);
      chk("t7_no_aw", 64'(aw_addr_l.size()), 64'd0);
      chk("t7_no_w", 64'(wd_l.size()), 64'd0);

      // reset mid-burst with data buffered
      w_rdy_cfg = 1'b0;
      start_xfer(32'h6000, 32'd64, 8, 64'h700, 1'b0);
      repeat (4) @(negedge ap_clk);
      chk("t8_pre_wvalid", {63'd0, wvalid}, 64'd1);
      chk("t8_pre_full_n", {63'd0, full_n}, 64'd0);
      prod_total = 0;
      #2 ap_rst = 1'b1;
      #1;
      chk("t8_rst_out", {56'd0, awvalid, wvalid, wlast, bready, full_n, ap_idle, ap_ready, ap_done},
          {56'd0, 8'b0000_1100});
      chk("t8_rst_aw", {awaddr, 24'd0, awlen}, 64'd0);
      @(negedge ap_clk) ap_rst = 1'b0;
      w_rdy_cfg = 1'b1;

      // recovery after reset
      start_xfer(32'h8000, 32'd16, 2, 64'h800, 1'b0);
      wait_done(200);
      chk_data("t9_data", 2, 64'h800);
      chk("t9_aw0", {aw_a(0), 24'd0, aw_l(0)}, {32'h8000, 24'd0, 8'd1});

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

   // absolute time guard
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
